// File: rtl/io_pkg.sv
// Shared definitions for the I/O unloader: state encoding, memory map and
// the word-count clamp applied when an unload starts.
package io_pkg;

   localparam int unsigned DIN_ADDR    = 'h3E00;
   localparam int unsigned DOUT_ADDR   = 'h3F00;
   localparam int unsigned MAX_IO_SIZE = 256;
   localparam int unsigned HALT_PC     = 'h14;

   typedef enum logic [2:0] {
      IDLE,
      READ,
      TAIL,
      OUT,
      DONE
   } state_t;

   // Negative counts unload nothing; oversized counts saturate at the region size.
   function automatic logic [31:0] clamp_limit(input logic signed [31:0] n,
                                               input logic        [31:0] max_words);
      logic [31:0] n_u;
      logic [31:0] res;
      n_u = n;
      if (n[31]) begin
         res = '0;
      end else if (n_u > max_words) begin
         res = max_words;
      end else begin
         res = n_u;
      end
      return res;
   endfunction

endpackage

// File: rtl/io_unloader.sv
// Unloads the output region of data memory after the processor halts:
// reads it byte by byte, assembles little-endian words and hands them to
// a ready/valid consumer, then reports done until halt drops.
module io_unloader
   import io_pkg::*;
#(
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned DATA_WIDTH  = 8,
   parameter int unsigned DOUT_ADDR   = io_pkg::DOUT_ADDR,
   parameter int unsigned MAX_IO_SIZE = io_pkg::MAX_IO_SIZE
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   halt,
   input  logic signed [31:0]     numWords,
   output logic                   rdEn,
   output logic [31:0]            rdAddr,
   input  logic [DATA_WIDTH-1:0]  rdData,
   output logic                   outValid,
   output logic [WIDTH-1:0]       outData,
   input  logic                   outReady,
   output logic                   outLast,
   output logic                   busy,
   output logic                   done
);

   localparam int unsigned BYTES     = WIDTH / DATA_WIDTH;
   localparam int unsigned BW        = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int unsigned MAX_WORDS = MAX_IO_SIZE / BYTES;
   localparam logic [BW-1:0] LAST_B  = BW'(BYTES - 1);

   state_t           state_q, state_d;
   logic [31:0]      w_q, w_d;
   logic [BW-1:0]    b_q, b_d;
   logic [31:0]      limit_q, limit_d;
   logic [WIDTH-1:0] data_q, data_d;

   logic             cap_en;
   logic [BW-1:0]    cap_lane;

   // Memory returns a byte one cycle after its read, so each READ cycle with
   // b>0 stores the byte requested by the previous cycle; TAIL stores the last.
   always_comb begin
      cap_en   = 1'b0;
      cap_lane = '0;
      if (state_q == READ && b_q != '0) begin
         cap_en   = 1'b1;
         cap_lane = b_q - BW'(1);
      end else if (state_q == TAIL) begin
         cap_en   = 1'b1;
         cap_lane = LAST_B;
      end
   end

   // Next-state logic for the unload sequencer and its counters.
   always_comb begin
      state_d = state_q;
      w_d     = w_q;
      b_d     = b_q;
      limit_d = limit_q;
      data_d  = data_q;

      if (cap_en) begin
         data_d[32'(cap_lane) * DATA_WIDTH +: DATA_WIDTH] = rdData;
      end

      case (state_q)
         IDLE: begin
            if (halt) begin
               limit_d = clamp_limit(numWords, 32'(MAX_WORDS));
               w_d     = '0;
               b_d     = '0;
               state_d = (limit_d == '0) ? DONE : READ;
            end
         end
         READ: begin
            b_d = b_q + BW'(1);
            if (b_q == LAST_B) begin
               state_d = TAIL;
            end
         end
         TAIL: begin
            state_d = OUT;
         end
         OUT: begin
            if (outReady) begin
               if (w_q + 32'd1 < limit_q) begin
                  w_d     = w_q + 32'd1;
                  b_d     = '0;
                  state_d = READ;
               end else begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            if (!halt) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset aborts any transfer in progress.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         w_q     <= '0;
         b_q     <= '0;
         limit_q <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         w_q     <= w_d;
         b_q     <= b_d;
         limit_q <= limit_d;
         data_q  <= data_d;
      end
   end

   // Outputs decode directly from registered state so reset clears them at once.
   always_comb begin
      rdEn     = (state_q == READ);
      rdAddr   = '0;
      if (state_q == READ) begin
         rdAddr = 32'(DOUT_ADDR) + (w_q * 32'(BYTES)) + 32'(b_q);
      end
      outValid = (state_q == OUT);
      outData  = data_q;
      outLast  = (state_q == OUT) && (w_q == limit_q - 32'd1);
      busy     = (state_q == READ) || (state_q == TAIL) || (state_q == OUT);
      done     = (state_q == DONE);
   end

endmodule
